// File: rtl/filter_pkg.sv
// Shared widths, FSM encoding and output scaling for the time-multiplexed FIR MAC engine.
package filter_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned N_TAPS    = 8;
  localparam int unsigned FRAC_BITS = 15;
  localparam int unsigned IDX_W     = $clog2(N_TAPS);
  localparam int unsigned PROD_W    = 2 * DATA_W;
  localparam int unsigned ACC_W     = PROD_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Arithmetic shift down to Q1.15 (floor), then clamp to the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0]  sh;
    logic signed [DATA_W-1:0] res;
    sh = acc >>> FRAC_BITS;
    if (sh[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){sh[ACC_W-1]}}) begin
      res = sh[DATA_W-1:0];
    end else if (sh[ACC_W-1]) begin
      res = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(DATA_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiply-accumulate; clear has priority over accumulate.
module mac_unit
  import filter_pkg::*;
#(
  parameter int unsigned IN_W  = DATA_W,
  parameter int unsigned OUT_W = ACC_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [OUT_W-1:0] acc_o
);

  logic signed [2*IN_W-1:0] prod_c;
  logic signed [OUT_W-1:0]  acc_d;
  logic signed [OUT_W-1:0]  acc_q;

  assign prod_c = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + OUT_W'(prod_c);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_engine.sv
// N-tap FIR stage: one accepted sample per pass, one signed MAC per cycle against a
// writable coefficient file, saturated Q1.15 result with a single-cycle valid pulse.
module fir_mac_engine
  import filter_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     coef_we,
  input  logic [IDX_W-1:0]         coef_addr,
  input  logic signed [DATA_W-1:0] coef_data,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     y_valid_q, y_valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic                     shift_c;
  logic                     acc_clr_c;
  logic                     acc_en_c;
  logic signed [ACC_W-1:0]  acc_c;

  logic signed [DATA_W-1:0] x_q [N_TAPS];
  logic signed [DATA_W-1:0] c_q [N_TAPS];

  // Sequencing: accept in IDLE, walk every tap in MAC, publish in OUT.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    overrun_d = overrun_q;
    shift_c   = 1'b0;
    acc_clr_c = 1'b0;
    acc_en_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sample_valid && enable) begin
          shift_c   = 1'b1;
          acc_clr_c = 1'b1;
          idx_d     = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        acc_en_c = 1'b1;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_TAPS - 1)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        y_d       = sat_shift(acc_c);
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Tap delay line moves only on an accepted sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(N_TAPS); k++) begin
        x_q[k] <= '0;
      end
    end else if (shift_c) begin
      x_q[0] <= sample_in;
      for (int k = 1; k < int'(N_TAPS); k++) begin
        x_q[k] <= x_q[k-1];
      end
    end
  end

  // Coefficient file is writable in every state; a same-edge MAC read sees the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(N_TAPS); k++) begin
        c_q[k] <= '0;
      end
    end else if (coef_we) begin
      c_q[coef_addr] <= coef_data;
    end
  end

  mac_unit #(
    .IN_W  (DATA_W),
    .OUT_W (ACC_W)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clr_i (acc_clr_c),
    .en_i  (acc_en_c),
    .a_i   (x_q[idx_q]),
    .b_i   (c_q[idx_q]),
    .acc_o (acc_c)
  );

  assign y_out   = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: timestamped behavioural model compared every cycle, plus
// directed scenarios with hand-computed results and a randomized soak.
module tb_fir_mac_engine;
  import filter_pkg::*;

  localparam int N = int'(N_TAPS);

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable = 1'b0;
  logic signed [DATA_W-1:0] sample_in = '0;
  logic                     sample_valid = 1'b0;
  logic                     coef_we = 1'b0;
  logic [IDX_W-1:0]         coef_addr = '0;
  logic signed [DATA_W-1:0] coef_data = '0;
  logic signed [DATA_W-1:0] y_out;
  logic                     y_valid;
  logic                     busy;
  logic                     overrun;

  int n_checks = 0;
  int n_pass   = 0;

  fir_mac_engine dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic signed [15:0] ref_sat(input longint s);
    longint q;
    q = s >>> FRAC_BITS;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  // Model: each edge is numbered; result for a sample accepted at edge T is the window
  // sum with tap k weighted by the coefficient file as it stood after edge T+k.
  int                     cyc;
  int                     t_acc;
  bit                     m_pending;
  bit                     m_busy;
  bit                     m_valid;
  bit                     m_ovr;
  logic signed [15:0]     m_y;
  longint                 hist [N_TAPS];
  longint                 win  [N_TAPS];
  longint                 coef [N_TAPS];
  longint                 ring [16][N_TAPS];

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      cyc = 0; t_acc = 0; m_pending = 0; m_busy = 0; m_valid = 0; m_ovr = 0; m_y = '0;
      for (int k = 0; k < N; k++) begin
        hist[k] = 0; win[k] = 0; coef[k] = 0;
        for (int r = 0; r < 16; r++) ring[r][k] = 0;
      end
    end else begin
      bit     busy_before;
      longint s;
      busy_before = m_busy;
      cyc++;
      m_valid = 0;
      if (m_pending && cyc == t_acc + N + 1) begin
        s = 0;
        for (int k = 0; k < N; k++) s += win[k] * ring[(t_acc + k) % 16][k];
        m_y = ref_sat(s);
        m_valid = 1;
        m_pending = 0;
      end
      if (sample_valid && busy_before) begin
        m_ovr = 1;
      end else if (sample_valid && enable) begin
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(sample_in);
        win = hist;
        t_acc = cyc;
        m_pending = 1;
      end
      if (coef_we) coef[coef_addr] = longint'(coef_data);
      ring[cyc % 16] = coef;
      m_busy = m_pending;
    end
  end

  initial forever begin
    @(posedge clock);
    #2;
    chk("y_out",   longint'(y_out),   longint'(m_y));
    chk("y_valid", longint'(y_valid), longint'(m_valid));
    chk("busy",    longint'(busy),    longint'(m_busy));
    chk("overrun", longint'(overrun), longint'(m_ovr));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] v);
    @(negedge clock);
    sample_in = v;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic wcoef(input int k, input logic signed [15:0] v);
    @(negedge clock);
    coef_we = 1'b1;
    coef_addr = IDX_W'(k);
    coef_data = v;
    @(negedge clock);
    coef_we = 1'b0;
  endtask

  task automatic wait_valid(input string name, output logic signed [15:0] y, output int lat);
    bit found;
    found = 0;
    lat = 0;
    y = '0;
    while (!found && lat < 40) begin
      @(posedge clock);
      #2;
      lat++;
      if (y_valid) begin
        found = 1;
        y = y_out;
      end
    end
    if (!found) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic count_valids(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clock);
      #2;
      if (y_valid) cnt++;
    end
  endtask

  initial begin
    logic signed [15:0] y;
    int lat;
    int cnt;

    tick(2);
    reset = 1'b0;
    enable = 1'b1;
    tick(1);
    chk("rst_y_out", longint'(y_out), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_overrun", longint'(overrun), 0);

    // Single tap and latency.
    wcoef(0, 16'sh4000);
    send(16'sh2000);
    wait_valid("t1", y, lat);
    chk("t1_y", longint'(y), longint'(16'sh1000));
    chk("t1_latency", lat, N + 1);
    chk("t1_model_y", longint'(m_y), longint'(16'sh1000));

    // Reset during MAC: outputs clear immediately, no result follows.
    send(16'sh2000);
    tick(3);
    reset = 1'b1;
    #1;
    chk("t5_async_y_out", longint'(y_out), 0);
    chk("t5_async_busy", longint'(busy), 0);
    tick(2);
    reset = 1'b0;
    count_valids(20, cnt);
    chk("t5_no_valid", cnt, 0);
    wcoef(0, 16'sh4000);
    send(16'sh2000);
    wait_valid("t5", y, lat);
    chk("t5_y", longint'(y), longint'(16'sh1000));

    // Delay line: only the oldest tap is weighted.
    do_reset();
    wcoef(7, 16'sh4000);
    for (int i = 1; i <= 8; i++) begin
      send(16'(i * 256));
      wait_valid("t2", y, lat);
      chk($sformatf("t2_y%0d", i), longint'(y), (i < 8) ? 0 : longint'(16'sh0080));
      tick(1);
    end

    // Positive saturation.
    do_reset();
    for (int k = 0; k < N; k++) wcoef(k, 16'sh7FFF);
    for (int i = 0; i < 8; i++) begin
      send(16'sh7FFF);
      wait_valid("t3p", y, lat);
      if (i == 0) chk("t3p_first", longint'(y), longint'(16'sh7FFE));
    end
    chk("t3p_y", longint'(y), longint'(16'sh7FFF));

    // Negative saturation.
    do_reset();
    for (int k = 0; k < N; k++) wcoef(k, 16'sh7FFF);
    for (int i = 0; i < 8; i++) begin
      send(16'sh8000);
      wait_valid("t3n", y, lat);
      if (i == 0) chk("t3n_first", longint'(y), longint'(16'sh8001));
    end
    chk("t3n_y", longint'(y), longint'(16'sh8000));

    // Overrun: second strobe three edges after acceptance is dropped.
    do_reset();
    wcoef(0, 16'sh4000);
    send(16'sh1000);
    tick(1);
    send(16'sh7000);
    wait_valid("t4", y, lat);
    chk("t4_y", longint'(y), longint'(16'sh0800));
    count_valids(15, cnt);
    chk("t4_single_valid", cnt, 0);
    chk("t4_overrun", longint'(overrun), 1);
    wcoef(0, 16'sh0000);
    wcoef(1, 16'sh4000);
    send(16'sh0000);
    wait_valid("t4b", y, lat);
    chk("t4_delay_line", longint'(y), longint'(16'sh0800));
    chk("t4_overrun_sticky", longint'(overrun), 1);

    // Coefficient write on the tap-0 MAC edge uses the old value; the next pass the new one.
    do_reset();
    wcoef(0, 16'sh4000);
    @(negedge clock);
    sample_in = 16'sh2000;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    coef_we = 1'b1;
    coef_addr = '0;
    coef_data = 16'sh7FFF;
    @(negedge clock);
    coef_we = 1'b0;
    wait_valid("t6a", y, lat);
    chk("t6_old_coef", longint'(y), longint'(16'sh1000));
    send(16'sh2000);
    wait_valid("t6b", y, lat);
    chk("t6_new_coef", longint'(y), longint'(16'sh1FFF));

    // Enable gating.
    enable = 1'b0;
    send(16'sh2000);
    chk("t6_gated_busy", longint'(busy), 0);
    count_valids(15, cnt);
    chk("t6_gated_no_valid", cnt, 0);
    chk("t6_gated_overrun", longint'(overrun), 0);
    enable = 1'b1;

    // Randomized soak with a mid-run reset.
    do_reset();
    for (int it = 0; it < 800; it++) begin
      @(negedge clock);
      reset = (it == 400);
      enable = ($urandom_range(0, 7) != 0);
      sample_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       sample_in = 16'sh7FFF;
        1:       sample_in = 16'sh8000;
        default: sample_in = 16'($urandom);
      endcase
      coef_we = ($urandom_range(0, 3) == 0);
      coef_addr = IDX_W'($urandom_range(0, N - 1));
      coef_data = ($urandom_range(0, 3) == 0) ? 16'sh7FFF : 16'($urandom);
    end
    @(negedge clock);
    reset = 1'b0;
    sample_valid = 1'b0;
    coef_we = 1'b0;
    tick(15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
